// File: rtl/fractal_sync_leaf_if.sv
// rtl/fractal_sync_leaf_if.sv - fractal_if: leaf-to-node synchronization tree port bundle
interface fractal_if #(
    parameter int LVL_WIDTH = 2
);
    logic                 sync;
    logic [LVL_WIDTH-1:0] level;
    logic                 ack;
    logic                 wake;
    logic                 error;

    // Leaf side drives sync/level/ack and observes wake/error from the node
    modport mst_port (
        output sync,
        output level,
        output ack,
        input  wake,
        input  error
    );

    modport slv_port (
        input  sync,
        input  level,
        input  ack,
        output wake,
        output error
    );
endinterface

// File: rtl/fractal_sync_leaf.sv
// rtl/fractal_sync_leaf.sv - barrier requester for one tree leaf; optional FRACTAL_SYNC_LEAF_TIMEOUT_EN wake timeout
module fractal_sync_leaf #(
    parameter int LVL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [LVL_WIDTH-1:0] req_level_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_error_o,
    output logic                 timeout_o,
    fractal_if.mst_port          sync_port
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_WAIT_WAKE,
        S_ACK,
        S_RELEASE,
        S_RESP
    } state_t;

    state_t               r_state;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_rsp_error;
    logic                 r_sync;
    logic                 r_ack;
    logic                 r_err;
    logic [LVL_WIDTH-1:0] r_level;

    logic w_req_hs;
    logic w_rsp_hs;

    assign w_req_hs = req_valid_i & r_req_ready;
    assign w_rsp_hs = rsp_ready_i & r_rsp_valid;

    assign req_ready_o     = r_req_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_error_o     = r_rsp_error;
    assign sync_port.sync  = r_sync;
    assign sync_port.ack   = r_ack;
    assign sync_port.level = r_level;

    // Barrier sequencer: all outputs are set on the transition into the state that owns them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_sync      <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_level     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_req_ready <= 1'b0;
                        if (req_level_i != '0) begin
                            r_level <= req_level_i;
                            r_err   <= 1'b0;
                            r_sync  <= 1'b1;
                            r_state <= S_SYNC;
                        end else begin
                            // No tree depth selected: answer locally with an error
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_SYNC: begin
                    r_sync  <= 1'b0;
                    r_state <= S_WAIT_WAKE;
                end
                S_WAIT_WAKE: begin
                    if (sync_port.wake) begin
                        r_err   <= r_err | sync_port.error;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Wake may still be held for slower siblings; wait for it to drop
                    if (!sync_port.wake) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= r_err;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                    r_sync      <= 1'b0;
                    r_ack       <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRACTAL_SYNC_LEAF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    assign timeout_o = r_timeout;

    // Saturating wait-for-wake counter with sticky flag, cleared by each accepted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (r_state == S_IDLE && w_req_hs) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (r_state == S_WAIT_WAKE) begin
            if (r_wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_o            = 1'b0;
`endif

endmodule

// File: doc/fractal_sync_leaf.md
# fractal_sync_leaf

Leaf-side requester for the fractal synchronization tree. It sits between a core (or its control-register block) and one slave port of a first-level `fractal_sync` node. It turns a single valid/ready barrier request carrying a level into the tree protocol: a sync pulse with its level, a wait for wake, and an ack. It then waits for the node to release wake and returns a response carrying the tree's error flag.

## Interface
Parameters:
- `LVL_WIDTH`, default 2: width of the level field; equals the first-level node's slave level width. Must be > 0.
- `TIMEOUT_CYCLES`, default 1024: wait-for-wake threshold. Only used when the timeout feature is compiled in. Must be > 0.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  1  core barrier request valid
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`
- `req_level_i`  in  LVL_WIDTH  barrier level; lowest set bit k selects the tree depth k at which the barrier resolves
- `rsp_valid_o`  out  1  barrier response valid
- `rsp_ready_i`  in  1  core accepts response
- `rsp_error_o`  out  1  tree or local error for this barrier; valid with `rsp_valid_o`
- `timeout_o`  out  1  sticky wait-for-wake timeout flag
- `sync_port`  fractal_if.mst_port  —  tree port; member widths: `sync` out 1, `level` out LVL_WIDTH, `ack` out 1, `wake` in 1, `error` in 1

## Operation
- The FSM has six states: IDLE, SYNC, WAIT_WAKE, ACK, RELEASE, RESP.
- Reset (`rst_i` high at a clock edge) puts the FSM in IDLE and drives these values:
  - `req_ready_o`=1, `rsp_valid_o`=0, `rsp_error_o`=0, `timeout_o`=0
  - `sync`=0, `ack`=0, `level`=0
  - internal error and counter registers cleared.
- IDLE:
  - `req_ready_o`=1.
  - On handshake with nonzero `req_level_i`: register the level into `level_q`, clear the error register and `timeout_o`, go to SYNC.
  - On handshake with `req_level_i`==0: set error, go directly to RESP; no tree activity.
- SYNC: `sync`=1 for exactly one cycle, then go to WAIT_WAKE.
- WAIT_WAKE: when `wake`==1 is sampled, OR `error` into the error register and go to ACK.
- ACK: `ack`=1 for exactly one cycle, then go to RELEASE.
- RELEASE: stay until `wake`==0 is sampled, then go to RESP. This prevents a wake still held for slower siblings from being taken as completion of the next barrier.
- RESP:
  - `rsp_valid_o`=1 and `rsp_error_o`=error register, both held stable until `rsp_ready_i`.
  - On handshake go to IDLE.
- `level` port:
  - Always driven from `level_q`, which is updated only at request handshake.
  - Held stable from SYNC through RESP and afterwards, until the next accepted request.
- `req_ready_o` is 0 in every state except IDLE; there is one outstanding barrier at most.
- Edge cases:
  - `wake` or `error` seen in IDLE, SYNC, ACK or RESP is ignored.
  - `error` is captured only on the cycle wake is first sampled in WAIT_WAKE.
  - `wake` already high in the SYNC cycle is not sampled; sampling starts in WAIT_WAKE.
- Reset mid-operation:
  - Returns to IDLE immediately; any pending response is dropped.
  - The tree above must be reset in the same cycle; partial barriers are not recovered.

## Timing
- Request handshake at cycle 0 gives `sync`=1 at cycle 1.
- If `wake` first goes high at cycle W (W ≥ 2), `ack`=1 at cycle W+1.
- If `wake` is first sampled low at cycle R (R ≥ W+2), `rsp_valid_o`=1 at cycle R+1.
- Zero-level request: handshake at 0 gives `rsp_valid_o`=1 at cycle 1 with `rsp_error_o`=1.
- Back-to-back:
  - Response handshake at cycle N returns to IDLE at N+1.
  - Next request may be accepted at N+1.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Configuration
- `FRACTAL_SYNC_LEAF_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles spent in WAIT_WAKE.
  - It is reset on entry to SYNC and saturates.
  - When it reaches TIMEOUT_CYCLES, `timeout_o` sets and stays 1 until the next accepted request or reset.
  - The barrier is not aborted; the FSM keeps waiting.
- Macro undefined: no counter is instantiated; `timeout_o` is tied to 0.

## Test plan
- Level 2'b01; wake asserted 5 cycles after sync and dropped 3 cycles later, error=0:
  - `sync` is a single pulse with `level`=01
  - `ack` one cycle after wake
  - `rsp_valid_o` one cycle after wake falls, `rsp_error_o`=0.
- Level 2'b10; wake and error=1 together:
  - `rsp_error_o`=1
  - next barrier with error=0 responds 0, so the error register clears per request.
- Level 0: response the cycle after handshake with error=1; `sync` and `ack` never assert.
- Wake held high 10 cycles after ack (slow sibling):
  - stays in RELEASE, no response
  - a new `req_valid_i` sees `req_ready_o`=0 until the response handshake completes.
- Reset asserted in WAIT_WAKE:
  - next cycle `sync`=0, `ack`=0, `rsp_valid_o`=0, `req_ready_o`=1
  - a later wake pulse in IDLE produces no ack.
- Timeout build, TIMEOUT_CYCLES=8, wake after 20 cycles:
  - `timeout_o` rises after 8 WAIT_WAKE cycles
  - barrier still completes normally
  - `timeout_o` clears on the next request; on a non-timeout build `timeout_o` stays 0.
